// File: rtl/line_buffer_feeder.sv
// Streams an 8-bit image from frame memory into the line-buffer ring, one line per credit.
// Optional LINE_FEEDER_PAD_EN appends two zero-pixel lines after the last image line.
module line_buffer_feeder #(
  parameter int IMG_WIDTH     = 256,
  parameter int IMG_HEIGHT    = 256,
  parameter int PRELOAD_LINES = 4,
  parameter int ADDR_W        = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_intr,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  output logic [7:0]        o_pixel_data,
  output logic              o_pixel_data_valid,
  output logic              o_busy,
  output logic              o_done
);

`ifdef LINE_FEEDER_PAD_EN
  localparam int TOTAL_LINES = IMG_HEIGHT + 2;
`else
  localparam int TOTAL_LINES = IMG_HEIGHT;
`endif
  localparam int COL_W  = $clog2(IMG_WIDTH + 1);
  localparam int LINE_W = $clog2(TOTAL_LINES + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [3:0]        credit_q, credit_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              p1_vld_q, p1_vld_d;
  logic [7:0]        pix_q, pix_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_ok_s;
  logic              consume_s;
  logic              add_s;
  logic              lines_remain_s;
`ifdef LINE_FEEDER_PAD_EN
  logic              p1_pad_q, p1_pad_d;
  logic              pad_next_s;
`endif

  assign start_ok_s     = i_start && (state_q == S_IDLE) && !busy_q;
  assign lines_remain_s = (int'(line_q) + 1) < TOTAL_LINES;

  // Credit counter: preload on start, minus one per line start, plus one per interrupt (saturating)
  always_comb begin
    consume_s = (state_q == S_SEND) && (col_q == '0);
    add_s     = i_intr && (state_q != S_IDLE);
    credit_d  = credit_q;
    if (start_ok_s) begin
      credit_d = 4'(PRELOAD_LINES);
    end else if (consume_s && !add_s) begin
      credit_d = credit_q - 4'd1;
    end else if (add_s && !consume_s && (credit_q != 4'hf)) begin
      credit_d = credit_q + 4'd1;
    end else begin
      credit_d = credit_q;
    end
  end

  // Frame sequencing; the line-end decision uses credit_d so a same-cycle interrupt counts
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok_s) begin
          state_d = S_SEND;
          col_d   = '0;
          line_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (col_q == LAST_COL) begin
          col_d  = '0;
          line_d = line_q + LINE_W'(1);
          if (lines_remain_s && (credit_d != 4'd0)) begin
            state_d = S_SEND;
          end else if (lines_remain_s) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      S_WAIT: begin
        if (credit_d != 4'd0) begin
          state_d = S_SEND;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (!p1_vld_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef LINE_FEEDER_PAD_EN
    pad_next_s = int'(line_d) >= IMG_HEIGHT;
    rd_d       = (state_d == S_SEND) && !pad_next_s;
`else
    rd_d       = (state_d == S_SEND);
`endif
  end

  // Running read address; holds while no memory read is issued
  always_comb begin
    if (start_ok_s) begin
      addr_d = '0;
    end else if (rd_d && (state_q != S_IDLE)) begin
      addr_d = addr_q + ADDR_W'(1);
    end else begin
      addr_d = addr_q;
    end
  end

  // Two-stage pixel pipeline: memory latency stage, then registered output
  always_comb begin
    p1_vld_d = (state_q == S_SEND);
    vld_d    = p1_vld_q;
`ifdef LINE_FEEDER_PAD_EN
    p1_pad_d = (state_q == S_SEND) && (int'(line_q) >= IMG_HEIGHT);
    if (p1_vld_q) begin
      pix_d = p1_pad_q ? 8'd0 : i_mem_data;
    end else begin
      pix_d = pix_q;
    end
`else
    if (p1_vld_q) begin
      pix_d = i_mem_data;
    end else begin
      pix_d = pix_q;
    end
`endif
    if (start_ok_s) begin
      busy_d = 1'b1;
    end else if (done_q) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      line_q   <= '0;
      credit_q <= 4'd0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      p1_vld_q <= 1'b0;
      pix_q    <= 8'd0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef LINE_FEEDER_PAD_EN
      p1_pad_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      line_q   <= line_d;
      credit_q <= credit_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      p1_vld_q <= p1_vld_d;
      pix_q    <= pix_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef LINE_FEEDER_PAD_EN
      p1_pad_q <= p1_pad_d;
`endif
    end
  end

  assign o_mem_rd           = rd_q;
  assign o_mem_addr         = addr_q;
  assign o_pixel_data       = pix_q;
  assign o_pixel_data_valid = vld_q;
  assign o_busy             = busy_q;
  assign o_done             = done_q;

endmodule

// File: tb/tb_line_buffer_feeder.sv
// Directed bench for line_buffer_feeder (4x6 image, memory content = address) with a stream model.
module tb_line_buffer_feeder;
  localparam int W  = 4;
  localparam int H  = 6;
  localparam int P  = 4;
  localparam int AW = 16;
`ifdef LINE_FEEDER_PAD_EN
  localparam int TL = H + 2;
`else
  localparam int TL = H;
`endif

  logic          clk;
  logic          i_rst;
  logic          i_start;
  logic          i_intr;
  logic          o_mem_rd;
  logic [AW-1:0] o_mem_addr;
  logic [7:0]    mem_data;
  logic [7:0]    o_pixel_data;
  logic          o_pixel_data_valid;
  logic          o_busy;
  logic          o_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // stream model state
  bit mon_en  = 0;
  bit active  = 0;
  int rd_k    = 0;
  int pix_k   = 0;
  int intr_seen = 0;
  int last_vld_cyc = -10;
  int rd_cyc [0:W*H-1];

  line_buffer_feeder #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PRELOAD_LINES(P), .ADDR_W(AW)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_intr(i_intr),
    .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr), .i_mem_data(mem_data),
    .o_pixel_data(o_pixel_data), .o_pixel_data_valid(o_pixel_data_valid),
    .o_busy(o_busy), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous memory, content equals address
  always @(posedge clk) if (o_mem_rd) mem_data <= o_mem_addr[7:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame();
    rd_k = 0; pix_k = 0; intr_seen = 0; active = 1;
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
  endtask

  task automatic drain_with_intr();
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (n < 400 && !seen) begin
      i_intr = ((n % 8) == 3);
      if (o_done) seen = 1;
      step(1);
      n++;
    end
    i_intr = 1'b0;
    chk("drain_done_seen", {31'd0, seen}, 32'd1);
    chk("drain_busy_low", {31'd0, o_busy}, 32'd0);
  endtask

  // Stream model compare: read order/credit, pixel value/latency, done placement
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_mem_rd) begin
        tests++;
        if (rd_k >= W*H || o_mem_addr != AW'(rd_k)) begin
          fails++;
          $display("FAIL read_addr: got %0d, expected %0d", o_mem_addr, rd_k);
        end
        tests++;
        if ((rd_k / W) >= P + intr_seen) begin
          fails++;
          $display("FAIL read_credit: line %0d read, only %0d lines credited", rd_k / W, P + intr_seen);
        end
        if (rd_k < W*H) rd_cyc[rd_k] = cyc;
        rd_k++;
      end
      if (o_pixel_data_valid) begin
        tests++;
        if (o_pixel_data !== ((pix_k < W*H) ? 8'(pix_k) : 8'd0)) begin
          fails++;
          $display("FAIL pix_value: got %0d, expected %0d (pixel %0d)", o_pixel_data,
                   (pix_k < W*H) ? (pix_k % 256) : 0, pix_k);
        end
        if (pix_k < W*H) begin
          tests++;
          if (pix_k >= rd_k || cyc != rd_cyc[pix_k] + 2) begin
            fails++;
            $display("FAIL pix_latency: pixel %0d at cycle %0d, read count %0d", pix_k, cyc, rd_k);
          end
        end
        pix_k++;
        last_vld_cyc = cyc;
      end
      if (o_done) begin
        tests++;
        if (pix_k != TL*W || last_vld_cyc != cyc - 1) begin
          fails++;
          $display("FAIL done_place: got %0d pixels, last at %0d, done at %0d, expected %0d pixels", pix_k, last_vld_cyc, cyc, TL*W);
        end
        active = 0;
      end
      if (active && i_intr) intr_seen++;
      if (i_rst) begin
        rd_k = 0; pix_k = 0; intr_seen = 0; active = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_rst = 1'b1; i_start = 1'b0; i_intr = 1'b0; mem_data = 8'd0;

    // Reset held 3 cycles with interrupts toggling
    for (int c = 0; c < 3; c++) begin
      i_intr = c[0];
      step(1);
    end
    chk("rst_rd", {31'd0, o_mem_rd}, 32'd0);
    chk("rst_addr", {16'd0, o_mem_addr}, 32'd0);
    chk("rst_pix", {23'd0, o_pixel_data_valid, o_pixel_data}, 32'd0);
    chk("rst_busy_done", {30'd0, o_busy, o_done}, 32'd0);
    i_rst = 1'b0; i_intr = 1'b0;
    mon_en = 1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      i_intr = (c == 1 || c == 3);
      if (o_mem_rd || o_busy) n++;
      step(1);
    end
    i_intr = 1'b0;
    chk("idle_intr_no_read", n, 0);

    // Frame 1: credit accounting, coincident intr, ignored restart, contiguous lines 4/5
    start_frame();
    chk("f1_first_read", {15'd0, o_mem_rd, o_mem_addr}, {15'd0, 1'b1, 16'd0});
    chk("f1_busy", {31'd0, o_busy}, 32'd1);
    n = 0;
    for (int c = 1; c <= 24; c++) begin
      i_start = (c == 3);
      i_intr  = (c == 5 || c == 9);
      if (o_mem_rd) n++;
      step(1);
    end
    i_start = 1'b0; i_intr = 1'b0;
    chk("f1_contiguous_reads", n, 24);
    chk("f1_rd_stops", {31'd0, o_mem_rd}, 32'd0);
`ifdef LINE_FEEDER_PAD_EN
    drain_with_intr();
`else
    step(1);
    chk("f1_last_pixel", {23'd0, o_pixel_data_valid, o_pixel_data}, {23'd0, 1'b1, 8'd23});
    chk("f1_done_early", {31'd0, o_done}, 32'd0);
    step(1);
    chk("f1_done", {30'd0, o_done, o_busy}, {30'd0, 1'b1, 1'b1});
    step(1);
    chk("f1_busy_fall", {30'd0, o_done, o_busy}, 32'd0);
`endif

    // Frame 2: preload 16 pixels, wait, resume on single interrupts
    start_frame();
    n = 0;
    for (int c = 1; c <= 16; c++) begin
      if (o_mem_rd) n++;
      if (c == 3) chk("f2_pix0_latency", {23'd0, o_pixel_data_valid, o_pixel_data}, {23'd0, 1'b1, 8'd0});
      step(1);
    end
    chk("f2_preload_reads", n, 16);
    n = 0;
    for (int c = 17; c <= 21; c++) begin
      if (o_mem_rd || !o_busy) n++;
      step(1);
    end
    chk("f2_wait_idle", n, 0);
    i_intr = 1'b1;
    step(1);
    i_intr = 1'b0;
    chk("f2_resume_addr16", {15'd0, o_mem_rd, o_mem_addr}, {15'd0, 1'b1, 16'd16});
    step(3);
    chk("f2_addr19", {15'd0, o_mem_rd, o_mem_addr}, {15'd0, 1'b1, 16'd19});
    step(1);
    chk("f2_wait_again", {15'd0, o_mem_rd, o_mem_addr}, {15'd0, 1'b0, 16'd19});
    step(5);
    i_intr = 1'b1;
    step(1);
    i_intr = 1'b0;
    chk("f2_resume_addr20", {15'd0, o_mem_rd, o_mem_addr}, {15'd0, 1'b1, 16'd20});
    step(3);
    chk("f2_addr23", {15'd0, o_mem_rd, o_mem_addr}, {15'd0, 1'b1, 16'd23});
    step(2);
    chk("f2_pixel23", {23'd0, o_pixel_data_valid, o_pixel_data}, {23'd0, 1'b1, 8'd23});
    step(1);
`ifdef LINE_FEEDER_PAD_EN
    chk("f2_no_done_before_pad", {31'd0, o_done}, 32'd0);
    i_intr = 1'b1;
    step(1);
    i_intr = 1'b0;
    chk("f2_pad_no_read", {30'd0, o_mem_rd, o_busy}, {30'd0, 1'b0, 1'b1});
    step(2);
    chk("f2_pad_pixel", {23'd0, o_pixel_data_valid, o_pixel_data}, {23'd0, 1'b1, 8'd0});
    drain_with_intr();
`else
    chk("f2_done", {30'd0, o_done, o_busy}, {30'd0, 1'b1, 1'b1});
    step(1);
    chk("f2_busy_fall", {31'd0, o_busy}, 32'd0);
`endif

    // Frame 3: reset at column 2 of line 1, then restart from address 0
    start_frame();
    step(6);
    chk("f3_line1_col2", {15'd0, o_mem_rd, o_mem_addr}, {15'd0, 1'b1, 16'd6});
    i_rst = 1'b1;
    step(1);
    i_rst = 1'b0;
    chk("f3_rst_outputs", {13'd0, o_mem_rd, o_mem_addr, o_pixel_data_valid, o_busy, o_done},
        32'd0);
    chk("f3_rst_pixel", {24'd0, o_pixel_data}, 32'd0);
    step(2);
    chk("f3_idle_after_rst", {30'd0, o_mem_rd, o_busy}, 32'd0);
    start_frame();
    chk("f3_restart_addr0", {15'd0, o_mem_rd, o_mem_addr}, {15'd0, 1'b1, 16'd0});
    step(2);
    chk("f3_restart_pix0", {23'd0, o_pixel_data_valid, o_pixel_data}, {23'd0, 1'b1, 8'd0});
    drain_with_intr();

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
